// File: rtl/serial_feeder.sv
// Parallel-to-serial front end for the bit-serial sequence detectors: W-bit words in over valid/ready, one bit per clock out on x.
// Define SERIAL_FEEDER_LSB_FIRST_EN to shift din[0] first instead of din[W-1].
module serial_feeder #(
  parameter int W  = 8,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         x_last,
  output logic         busy
);

  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   shreg_reg, shreg_next, shreg_shifted;
  logic [CW-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic           x_valid_reg, x_valid_next;
  logic           x_last_reg, x_last_next;
  logic           at_last;
  logic           accept;

  // Ready on the last-bit cycle too, so back-to-back words leave no bubble on x.
  assign at_last   = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
  assign din_ready = rst && ((state_reg == IDLE) || at_last);
  assign accept    = din_valid && din_ready;
  assign cnt_inc   = cnt_reg + 1'b1;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
  assign x             = shreg_reg[0];
  assign shreg_shifted = shreg_reg >> 1;
`else
  assign x             = shreg_reg[W-1];
  assign shreg_shifted = shreg_reg << 1;
`endif

  assign x_valid = x_valid_reg;
  assign x_last  = x_last_reg;
  assign busy    = (state_reg == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      x_valid_reg <= 1'b0;
      x_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      cnt_reg     <= cnt_next;
      x_valid_reg <= x_valid_next;
      x_last_reg  <= x_last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (at_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shreg_next   = shreg_reg;
    cnt_next     = cnt_reg;
    x_valid_next = x_valid_reg;
    x_last_next  = x_last_reg;
    if (accept) begin
      shreg_next   = din;
      cnt_next     = '0;
      x_valid_next = 1'b1;
      x_last_next  = (W == 1);
    end else if (state_reg == SHIFT) begin
      if (!at_last) begin
        shreg_next  = shreg_shifted;
        cnt_next    = cnt_inc;
        x_last_next = (cnt_inc == LAST_CNT);
      end else begin
        // Word finished with nothing queued: park x at 0.
        shreg_next   = '0;
        x_valid_next = 1'b0;
        x_last_next  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Directed self-checking bench for serial_feeder (W=8): single word, back-to-back, stall, ignored input, mid-word reset.
module tb_serial_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       x;
  logic       x_valid;
  logic       x_last;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  serial_feeder #(.W(8), .CW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .x_last    (x_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_bit(input logic [7:0] word, input int i);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    return word[i];
`else
    return word[7-i];
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_xv"}, 32'(x_valid), 32'd0);
    check({tag, "_xl"}, 32'(x_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(din_ready), 32'd1);
  endtask

  // Offer word a (and b back-to-back when two=1), then check every serial bit and the idle tail.
  task automatic stream2(input logic [7:0] a, input logic [7:0] b, input bit two);
    logic [7:0] word;
    @(posedge clk); #1;
    din = a;
    din_valid = 1'b1;
    @(negedge clk);
    check("rdy_offer", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    // While busy, present the next word (or garbage) so ignored-input behaviour is exercised.
    if (two) din = b;
    else begin
      din_valid = 1'b0;
      din = ~a;
    end
    for (int j = 0; j < (two ? 2 : 1); j++) begin
      word = (j == 0) ? a : b;
      if (j == 1) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = ~b;
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check($sformatf("x_w%0h_b%0d", word, i), 32'(x), 32'(exp_bit(word, i)));
        check($sformatf("xv_w%0h_b%0d", word, i), 32'(x_valid), 32'd1);
        check($sformatf("xl_w%0h_b%0d", word, i), 32'(x_last), 32'(i == 7));
        check($sformatf("rdy_w%0h_b%0d", word, i), 32'(din_ready), 32'(i == 7));
        check($sformatf("busy_w%0h_b%0d", word, i), 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    check_idle("tail");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    din = 8'h00;
    din_valid = 1'b1;
    #3;
    check("rst_x", 32'(x), 32'd0);
    check("rst_xv", 32'(x_valid), 32'd0);
    check("rst_xl", 32'(x_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Single word, then back-to-back with din changing while busy.
    stream2(8'b1001_1000, 8'h00, 1'b0);
    stream2(8'hA5, 8'h3C, 1'b1);

    // Stall for 5 cycles, then a fresh word.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle($sformatf("stall%0d", k));
    end
    stream2(8'h01, 8'h00, 1'b0);

    // Reset during bit 4 of 8'hFF.
    @(posedge clk); #1;
    din = 8'hFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ff_x_b%0d", i), 32'(x), 32'd1);
    end
    @(posedge clk); #2;
    din_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_x", 32'(x), 32'd0);
    check("mid_rst_xv", 32'(x_valid), 32'd0);
    check("mid_rst_xl", 32'(x_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy", 32'(din_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold_busy", 32'(busy), 32'd0);
    check("mid_rst_hold_xv", 32'(x_valid), 32'd0);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    check_idle("post_mid_rst");
    stream2(8'h0F, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
- Parallel-to-serial front end for the bit-serial sequence detectors.
- Accepts W-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock on x, the detector's serial input, and flags which bits are real data.
- Supports gapless back-to-back words, so the detector sees patterns that cross word boundaries.

Parameters:
- W, 8: word width in bits; legal range 2..32.
- CW, 5: bit-counter width; must satisfy 2**CW >= W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; single clock domain.
- din  input  W  parallel word; sampled only on an accepted handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  feeder can accept a word this cycle.
- x  output  1  serial data bit to the detector; registered.
- x_valid  output  1  x carries a data bit this cycle; registered.
- x_last  output  1  x carries the final bit of a word; registered.
- busy  output  1  a word is being shifted (state SHIFT).

Behaviour:
- Registers: state {IDLE, SHIFT}, shreg[W-1:0], cnt[CW-1:0], x_valid, x_last.
- Outputs: x = shreg[W-1], i.e. MSB first.
- Reset (rst low, async):
  - state=IDLE, shreg=0, cnt=0.
  - x=0, x_valid=0, x_last=0, busy=0.
  - din_ready forced 0 while rst is low.
- din_ready is combinational: rst && (state==IDLE || (state==SHIFT && cnt==W-1)).
- Accept = din_valid && din_ready at a rising edge.
- On accept:
  - shreg<=din, cnt<=0, state<=SHIFT, x_valid<=1, x_last<=(W==1 ? 1 : 0).
  - Latency: first bit (din[W-1]) appears on x in the cycle right after the accepting edge.
- In SHIFT with cnt<W-1, each edge:
  - shreg<=shreg<<1 with zero fill; cnt<=cnt+1.
  - x_last<=(cnt+1==W-1).
- In SHIFT with cnt==W-1 (last bit on x):
  - If accept: load as above. No bubble; the next word's MSB follows the previous LSB on the next cycle.
  - Else: state<=IDLE, shreg<=0, x_valid<=0, x_last<=0.
- IDLE with no accept: hold everything; x=0, x_valid=0.
- Idle level of x is 0, and the detector still samples it. Upstream must therefore stream continuously when pattern continuity across gaps matters.
- din_valid may drop without an accept; nothing is captured. din changes while din_ready=0 are ignored.
- Exactly W x_valid cycles per accepted word. x_last is high on exactly one of them: the W-th.
- Reset mid-word: the word is discarded immediately and asynchronously. No partial completion after rst rises; the first post-reset accept starts a fresh word.
- busy==(state==SHIFT), registered-equivalent.
- Back-to-back throughput: one word per W cycles.

Optional Feature:
- Macro: SERIAL_FEEDER_LSB_FIRST_EN.
- Defined:
  - x = shreg[0]; shifting is shreg>>1 with zero fill.
  - The word goes out din[0] first. Handshake, counts, x_last and latency are unchanged.
- Undefined: MSB-first as above.

Test Plan:
- Reset, then W=8, din=8'b1001_1000 with din_valid for one cycle:
  - din_ready=1 in that cycle.
  - x=1,0,0,1,1,0,0,0 on the next 8 cycles; x_valid high for exactly those 8.
  - x_last only on the 8th; then x=0, x_valid=0, busy=0.
  - Attached detector z goes high once.
- Back-to-back: din_valid held with 8'hA5 then 8'h3C:
  - din_ready pulses on the last-bit cycle of each word.
  - x stream 10100101 00111100 with no gap.
  - x_valid continuous for 16 cycles.
- Stall: din_valid=0 for 5 cycles after a word completes:
  - x_valid=0, din_ready=1, x=0 throughout.
  - Next word starts 1 cycle after its accept.
- Ignored input: din changed while busy with din_valid=1 but din_ready=0:
  - Current word's bits unaffected.
  - The new word is taken only at the last-bit edge.
- Reset mid-word: assert rst during bit 4 of 8'hFF:
  - x, x_valid, x_last and busy drop to 0 asynchronously; din_ready=0 during reset.
  - After release, 8'h0F shifts as 00001111.
- With SERIAL_FEEDER_LSB_FIRST_EN: din=8'b0000_0001 gives x=1,0,0,0,0,0,0,0, with x_last on the 8th bit.
